// File: rtl/cosx_host_pkg.sv
// Shared types for the cosx accelerator host sequencer.
// Request layout, FSM encoding and operand width.
package cosx_host_pkg;

  localparam int COSX_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  typedef struct packed {
    logic [COSX_W-1:0] x;
    logic [COSX_W-1:0] y;
  } cosx_req_t;

endpackage

// File: rtl/cosx_req_fifo.sv
// Show-ahead synchronous request FIFO for cosx_host.
// Full/empty come from the registered count only.
module cosx_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cosx_host.sv
// Host-side sequencer for the cosx accelerator: buffers requests,
// runs the start/ready handshake and returns results in order.
module cosx_host
  import cosx_host_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COSX_W-1:0] req_x,
  input  logic [COSX_W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [COSX_W-1:0] rsp_cosx,
  output logic              rsp_timeout,
  output logic              acc_start,
  output logic [COSX_W-1:0] acc_x,
  output logic [COSX_W-1:0] acc_y,
  input  logic              acc_ready,
  input  logic [COSX_W-1:0] acc_cosx
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              acc_ready_q;
  logic [COSX_W-1:0] acc_x_q, acc_x_d;
  logic [COSX_W-1:0] acc_y_q, acc_y_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [COSX_W-1:0] rsp_cosx_q, rsp_cosx_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  cosx_req_t fifo_din, fifo_dout;
  logic      fifo_full, fifo_empty, fifo_pop;
  logic      acc_done;

  assign fifo_din = '{x: req_x, y: req_y};

  cosx_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cosx_req_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Only a fresh 0->1 transition counts; a level left high is ignored.
  assign acc_done = !acc_ready_q && acc_ready;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_x_d       = acc_x_q;
    acc_y_d       = acc_y_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_cosx_d    = rsp_cosx_q;
    rsp_timeout_d = rsp_timeout_q;
    fifo_pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          acc_x_d  = fifo_dout.x;
          acc_y_d  = fifo_dout.y;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (acc_done) begin
          rsp_cosx_d    = acc_cosx;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end else if (cnt_inc == CNT_LAST) begin
          rsp_cosx_d    = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      acc_ready_q   <= 1'b0;
      acc_x_q       <= '0;
      acc_y_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_cosx_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_ready_q   <= acc_ready;
      acc_x_q       <= acc_x_d;
      acc_y_q       <= acc_y_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cosx_q    <= rsp_cosx_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = !fifo_full;
  assign acc_start   = (state_q == ST_ISSUE);
  assign acc_x       = acc_x_q;
  assign acc_y       = acc_y_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_cosx    = rsp_cosx_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_cosx_host.sv
// Randomized scoreboard bench for cosx_host with a cosx responder model.
// Expected results queue at request acceptance; a monitor pops on response.
module tb_cosx_host;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int N_RAND  = 40;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } req_s;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_x = '0;
  logic [15:0] req_y = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_cosx;
  logic        rsp_timeout;
  logic        acc_start;
  logic [15:0] acc_x, acc_y;
  logic        acc_ready;
  logic [15:0] acc_cosx;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n_rsp = 0;

  int rsp_mode = 1;
  int acc_mode = 0;
  int acc_lat  = 5;

  cosx_host #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_cosx    (rsp_cosx),
    .rsp_timeout (rsp_timeout),
    .acc_start   (acc_start),
    .acc_x       (acc_x),
    .acc_y       (acc_y),
    .acc_ready   (acc_ready),
    .acc_cosx    (acc_cosx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] rotr(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Consumer: 0 = stall, 1 = always ready, 2 = random.
  always @(posedge clock) begin
    #1;
    case (rsp_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Accelerator model: 0 = answers after latency, 1 = silent, 2 = stuck high.
  logic        st_s;
  logic [15:0] x_s, x_l;
  int          lat;

  always @(negedge clock) begin
    st_s = acc_start;
    x_s  = acc_x;
  end

  always @(posedge clock) begin
    if (reset) begin
      acc_ready <= 1'b1;
      acc_cosx  <= '0;
      lat       <= 0;
    end else if (acc_mode == 2) begin
      acc_ready <= 1'b1;
    end else if (st_s) begin
      acc_ready <= 1'b0;
      x_l       <= x_s;
      if (acc_mode == 1)     lat <= 0;
      else if (acc_lat == 0) lat <= $urandom_range(1, 10);
      else                   lat <= acc_lat;
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        acc_ready <= 1'b1;
        acc_cosx  <= rotr(x_l);
      end
    end
  end

  // Scoreboard state
  logic [16:0] exp_q[$];
  req_s        iss_q[$];
  int          fifo_cnt, start_cyc, rise_cyc, exp_start_cyc;
  bit          inflight, got_rsp, exp_start_v;
  bit          prev_start, prev_ready, push_now, acc_now;
  logic [16:0] held, e;
  logic [15:0] last_x, last_y;
  req_s        r;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      iss_q.delete();
      fifo_cnt    = 0;
      inflight    = 0;
      got_rsp     = 0;
      exp_start_v = 0;
      prev_start  = 0;
      prev_ready  = 0;
      rise_cyc    = -1;
      last_x      = '0;
      last_y      = '0;
    end else begin
      push_now = 0;
      acc_now  = 0;
      if (acc_start) begin
        chk("start_width", prev_start, 0);
        chk("start_busy", inflight, 0);
        if (exp_start_v) chk("start_latency", cyc, exp_start_cyc);
        exp_start_v = 0;
        if (iss_q.size() == 0) begin
          chk("start_unexpected", acc_start, 0);
        end else begin
          r = iss_q.pop_front();
          chk("acc_x", acc_x, r.x);
          chk("acc_y", acc_y, r.y);
          last_x = r.x;
          last_y = r.y;
          fifo_cnt--;
        end
        inflight  = 1;
        got_rsp   = 0;
        start_cyc = cyc;
        rise_cyc  = -1;
      end else begin
        if (exp_start_v && cyc >= exp_start_cyc) begin
          chk("start_missing", acc_start, 1);
          exp_start_v = 0;
        end
        chk("acc_xy_hold", {acc_x, acc_y}, {last_x, last_y});
      end

      chk("req_ready", req_ready, fifo_cnt < DEPTH);
      if (req_valid && req_ready) begin
        iss_q.push_back('{x: req_x, y: req_y});
        fifo_cnt++;
        push_now = 1;
      end

      if (inflight && !got_rsp && rise_cyc < 0 && acc_ready &&
          !prev_ready && cyc > start_cyc &&
          cyc <= start_cyc + TIMEOUT - 1)
        rise_cyc = cyc;

      if (rsp_valid) begin
        if (!inflight) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          if (!got_rsp) begin
            chk("rsp_latency", cyc,
                rise_cyc >= 0 ? rise_cyc + 1 : start_cyc + TIMEOUT);
            got_rsp = 1;
            held    = {rsp_timeout, rsp_cosx};
          end else begin
            chk("rsp_stable", {rsp_timeout, rsp_cosx}, held);
          end
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              chk("rsp_no_expect", rsp_valid, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_data", {rsp_timeout, rsp_cosx}, e);
            end
            inflight = 0;
            acc_now  = 1;
            n_rsp++;
          end
        end
      end else if (inflight && got_rsp) begin
        chk("rsp_dropped", rsp_valid, 1);
        inflight = 0;
      end else if (inflight && cyc > start_cyc + TIMEOUT) begin
        chk("rsp_missing", rsp_valid, 1);
        inflight = 0;
      end

      if (!inflight && fifo_cnt > 0 && !exp_start_v &&
          (push_now || acc_now)) begin
        exp_start_v   = 1;
        exp_start_cyc = cyc + 2;
      end
      prev_start = acc_start;
      prev_ready = acc_ready;
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    req_x     = x;
    req_y     = y;
    req_valid = 1'b1;
    @(negedge clock);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!req_ready) chk("req_accept_wait", req_ready, 1);
    else if (acc_mode == 0) exp_q.push_back({1'b0, rotr(x)});
    else exp_q.push_back({1'b1, 16'h0000});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || inflight) && n < 2000) begin
      n++;
      @(negedge clock);
    end
    if (exp_q.size() != 0 || inflight)
      chk("drain_wait", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_cosx", rsp_cosx, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_acc_x", acc_x, 0);
    chk("rst_acc_y", acc_y, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    reset_checks();
    @(posedge clock);
    #1;

    // single request
    send(16'h0200, 16'h0006);
    drain();

    // fill the FIFO back-to-back
    for (int i = 0; i < 5; i++)
      send(16'h0100 + 16'(i * 16'h1111), 16'(i));
    drain();

    // response backpressure
    rsp_mode = 0;
    send(16'h1234, 16'h0001);
    send(16'h4321, 16'h0002);
    for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clock);
    chk("bp_rsp_seen", rsp_valid, 1);
    repeat (10) @(posedge clock);
    #1 rsp_mode = 1;
    drain();

    // timeout, then a working request
    acc_mode = 1;
    send(16'h0bad, 16'h0003);
    drain();
    acc_mode = 0;
    send(16'h0f0f, 16'h0004);
    drain();

    // ready stuck high
    acc_mode = 2;
    repeat (2) @(posedge clock);
    #1;
    send(16'h7777, 16'h0005);
    drain();
    acc_mode = 0;
    repeat (2) @(posedge clock);
    #1;

    // reset while one request is in flight and two are queued
    acc_lat = 10;
    send(16'h1111, 16'h0010);
    send(16'h2222, 16'h0020);
    send(16'h3333, 16'h0030);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    reset_checks();
    repeat (30) @(posedge clock);
    #1;
    acc_lat = 5;
    send(16'h5a5a, 16'h0040);
    drain();

    // randomized traffic with random consumer stalls and latencies
    rsp_mode = 2;
    acc_lat  = 0;
    for (int i = 0; i < N_RAND; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clock);
        #1;
      end
      send(16'($urandom), 16'($urandom));
    end
    drain();

    chk("rsp_count", n_rsp, 52);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cosx_host.md
# cosx_host

Initiator-side sequencer for the `cosx` accelerator. It accepts cosine requests (x, y) on a valid/ready stream and buffers them in a small FIFO. It drives the accelerator's one-cycle `start` / `ready` completion handshake and returns each result on a valid/ready response stream. It sits between the system datapath and `cosx`, so the datapath never handles accelerator timing directly.

## Interface
Parameters:
- `DEPTH`, default 4: request FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT`, default 1024: maximum cycles to wait for accelerator completion; must be ≥2.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept a request.
- `req_x`  in  16  angle operand, opaque to this block.
- `req_y`  in  16  iteration/term operand, opaque to this block.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_cosx`  out  16  accelerator result; 0 on timeout.
- `rsp_timeout`  out  1  qualifies `rsp_valid`; 1 means the accelerator never completed.
- `acc_start`  out  1  to `cosx` start; one-cycle pulse.
- `acc_x`  out  16  to `cosx` x.
- `acc_y`  out  16  to `cosx` y.
- `acc_ready`  in  1  from `cosx` ready.
- `acc_cosx`  in  16  from `cosx` result.

## Operation
- **Request push:** when `req_valid && req_ready`, {x, y} is written at the FIFO tail.
  - `req_ready` = !full, from registered count only; no combinational path from the pop side.
  - A push while full is not taken, even if a pop occurs the same cycle.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head into `acc_x`/`acc_y` registers and go to ISSUE.
  - ISSUE: `acc_start`=1 for exactly this cycle. Clear the wait counter and go to WAIT.
  - WAIT: increment the counter each cycle. Completion is a rising edge of `acc_ready` (registered `acc_ready_q`==0 and `acc_ready`==1).
    - On completion: register `acc_cosx` into `rsp_cosx`, set `rsp_timeout`=0, set `rsp_valid`=1, go to HOLD.
    - Otherwise, if the counter reaches TIMEOUT-1: set `rsp_cosx`=0, `rsp_timeout`=1, `rsp_valid`=1, go to HOLD.
    - If completion and timeout occur in the same cycle, completion wins.
  - HOLD: `rsp_*` held stable. On `rsp_ready` clear `rsp_valid` and go to IDLE.
- `acc_x`/`acc_y` stay stable from ISSUE until the next pop.
- An `acc_ready` level that is high at start and never toggles does not count as completion; only a 0→1 edge after ISSUE counts.
- Only one request is outstanding at the accelerator at a time. Responses are returned in request order.
- Pushes continue in all FSM states while the FIFO has room.

## Timing
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `rsp_cosx`=0, `rsp_timeout`=0, `acc_start`=0, `acc_x`=0, `acc_y`=0. FIFO is emptied, FSM goes to IDLE, counter=0, `acc_ready_q`=0.
- **Request to start:** a request pushed at edge N into an empty FIFO is popped at edge N+1, and `acc_start` is high in cycle N+2.
- **Completion to response:** a `ready` edge sampled at edge M gives `rsp_valid`=1 after edge M.
- **Response to next start:** a response accepted at edge R moves the FSM to IDLE. If the FIFO is non-empty, the next `acc_start` is high in cycle R+2.
- **Reset mid-operation:** any in-flight request and all buffered requests are dropped, and no response is produced. `cosx` shares `reset`, so the accelerator is also cleared.
- **Counter width:** $clog2(TIMEOUT). It does not wrap in WAIT.
- **FIFO pointers:** $clog2(DEPTH) bits wide and wrap naturally. Count is $clog2(DEPTH)+1 bits wide.

## Structure
- Package `cosx_host_pkg`:
  - FSM state enum.
  - `COSX_W`=16.
  - A request struct {x, y}.
- Sub-module `cosx_req_fifo`: synchronous FIFO with parameters `DEPTH` and `WIDTH`=32. Ports: push, pop, din, dout (show-ahead), full, empty.
- The FSM, wait counter, `acc_ready` edge register and response registers live in `cosx_host`.

## Test plan
Each scenario uses a bench responder model: it lowers `ready` on `start`, raises `ready` after L cycles, and returns a fixed function of x.
- **Single request:** push x=0x0200, y=0x0006; responder with L=5, result 0x0100.
  - `acc_start` is one cycle wide, 2 cycles after the push.
  - `acc_x`=0x0200 and `acc_y`=0x0006 throughout.
  - `rsp_valid` with `rsp_cosx`=0x0100 and `rsp_timeout`=0, 1 cycle after the `ready` edge.
- **FIFO fill:** push 5 requests back-to-back with DEPTH=4 and `rsp_ready`=1.
  - `req_ready` drops after 4 entries are buffered.
  - All 5 responses arrive in push order with the matching results.
- **Response backpressure:** hold `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - `rsp_cosx` is unchanged and no second `acc_start` is issued.
  - After release, the next start occurs 2 cycles later.
- **Timeout:** responder never raises `ready`, TIMEOUT=16.
  - `rsp_valid` with `rsp_timeout`=1 and `rsp_cosx`=0, exactly 16 cycles after the `acc_start` cycle.
  - Then a second request with a working responder completes normally.
- **Stuck-high ready:** `acc_ready` is held at 1 across start.
  - No completion is taken.
  - The result is a timeout.
- **Reset mid-WAIT:** assert `reset` for 1 cycle while 2 requests are queued and 1 is in flight.
  - All outputs return to reset values.
  - No response is produced for the dropped requests.
  - A fresh request afterwards completes normally.
